fib_stack_engine: RTL

- Parametrised successor of the stack-driven Fibonacci controller.
- Evaluates a generalised second-order sequence: G(0)=base0, G(1)=base1, G(k)=G(k-1)+G(k-2). This covers Fibonacci (0,1), Lucas (2,1) and arbitrary seeds.
- Recursion runs on an internal LIFO of pending indices, with a start/busy/done handshake.
- Adds configurable widths, configurable stack depth, overflow and stack-error detection, and a peak-occupancy monitor.

---
 rtl/fib_pkg.sv | 9 +
 rtl/fib_lifo.sv | 56 +++++
 rtl/fib_stack_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared state encoding and leaf indices for the stack-driven sequence engine.
package fib_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, POP, EVAL, PUSH1, PUSH2, FIN} state_e;

  localparam int LEAF0 = 0;
  localparam int LEAF1 = 1;

endpackage

// File: rtl/fib_lifo.sv
// LIFO of pending indices: synchronous push/pop, registered read data, async reset
// plus a synchronous clear. A push while full is dropped; the caller sees it through full.
module fib_lifo #(
  parameter int W     = 5,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     rdata_q;
  logic [PTR_W-1:0] count_q, count_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (count_q == PTR_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - PTR_W'(1));
  assign rdata   = rdata_q;
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)          count_d = '0;
    else if (do_push) count_d = count_q + PTR_W'(1);
    else if (do_pop)  count_d = count_q - PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata;
    if (do_pop)  rdata_q       <= mem_q[rd_idx];
  end

  push_pop_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/fib_stack_engine.sv
// Second-order sequence engine G(k)=G(k-1)+G(k-2) with seeds base0/base1, evaluated
// by explicit recursion on a LIFO of pending indices; start/busy/done handshake.
module fib_stack_engine
  import fib_pkg::*;
#(
  parameter int N_W    = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  input  logic [DATA_W-1:0] base0,
  input  logic [DATA_W-1:0] base1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              stack_err,
  output logic [PTR_W-1:0]  peak
);

  state_e              state_q, state_d;
  logic [N_W-1:0]      n_q;
  logic [DATA_W-1:0]   base0_q, base1_q;
  logic [DATA_W-1:0]   acc_q, acc_d, result_q, result_d, leaf;
  logic [DATA_W:0]     sum;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic [PTR_W-1:0]    peak_q, peak_d, cnt_inc;
  logic                latch, push, pop, clr;
  logic [N_W-1:0]      wdata, k;
  logic                empty, full;
  logic [PTR_W-1:0]    count;

  fib_lifo #(.W(N_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (k),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign leaf    = (k == N_W'(LEAF0)) ? base0_q : base1_q;
  assign sum     = {1'b0, acc_q} + {1'b0, leaf};
  assign cnt_inc = count + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    peak_d   = peak_q;
    result_d = result_q;
    latch    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    wdata    = '0;
    case (state_q)
      IDLE: if (start) begin
        latch   = 1'b1;
        clr     = 1'b1;
        acc_d   = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        peak_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        push    = 1'b1;
        wdata   = n_q;
        state_d = POP;
      end
      POP: begin
        pop     = 1'b1;
        state_d = EVAL;
      end
      EVAL: if (k <= N_W'(LEAF1)) begin
        acc_d   = sum[DATA_W-1:0];
        ovf_d   = ovf_q | sum[DATA_W];
        state_d = empty ? FIN : POP;
      end else begin
        state_d = PUSH1;
      end
      PUSH1: begin
        push    = 1'b1;
        wdata   = k - N_W'(1);
        state_d = PUSH2;
      end
      PUSH2: begin
        push    = 1'b1;
        wdata   = k - N_W'(2);
        state_d = POP;
      end
      FIN: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A push into a full LIFO aborts the job with a zero result.
    if (push) begin
      if (full) begin
        err_d   = 1'b1;
        state_d = FIN;
      end else if (cnt_inc > peak_q) begin
        peak_d = cnt_inc;
      end
    end
    if (state_d == FIN) result_d = err_d ? '0 : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      peak_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      peak_q   <= peak_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      n_q     <= n_in;
      base0_q <= base0;
      base1_q <= base1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign stack_err = err_q;
  assign peak      = peak_q;

endmodule
